// File: rtl/data_mem_resp_if.sv
// rtl/data_mem_resp_if.sv - core data-memory bus plus debug byte stream
interface data_mem_resp_if;
   logic        memwrite;
   logic [31:0] addr;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        dbg_valid;
   logic        dbg_ready;
   logic [7:0]  dbg_data;

   modport master (
      output memwrite, addr, writedata, dbg_ready,
      input  readdata, dbg_valid, dbg_data
   );

   modport slave (
      input  memwrite, addr, writedata, dbg_ready,
      output readdata, dbg_valid, dbg_data
   );
endinterface

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - data RAM plus MMIO page (LED, timer, debug TX FIFO, status)
module data_mem_resp #(
   parameter int          DEPTH      = 1024,
   parameter int          ADDR_W     = 10,
   parameter logic [15:0] MMIO_PAGE  = 16'hFFFF,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   data_mem_resp_if.slave        bus,
   output logic [15:0]           led,
   output logic                  err
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];

   logic [31:0]       ram [DEPTH];
   logic [31:0]       timer;
   logic [7:0]        fifo [FIFO_DEPTH];
   logic [PW-1:0]     wptr, rptr;
   logic [PW:0]       count;
   logic              tx_ovf, misalign;

   logic [15:0]       off;
   logic [ADDR_W-1:0] idx;
   logic              mmio, aligned, wr_ok, ram_we;
   logic              sel_led, sel_tmr, sel_tx, sel_st;
   logic              full, pop, push_req, push, ovf_set, misalign_set;
   logic [2:0]        cnt3;

   assign off      = bus.addr[15:0];
   assign idx      = bus.addr[ADDR_W+1:2];
   assign mmio     = (bus.addr[31:16] == MMIO_PAGE);
   assign aligned  = (bus.addr[1:0] == 2'b00);
   assign wr_ok    = bus.memwrite & aligned;
   assign sel_led  = mmio & (off == 16'h0000);
   assign sel_tmr  = mmio & (off == 16'h0004);
   assign sel_tx   = mmio & (off == 16'h0008);
   assign sel_st   = mmio & (off == 16'h000C);

   // RAM is not reset, but a write landing while reset is held is discarded
   assign ram_we   = rst & wr_ok & ~mmio;

   assign full         = (count == FULL_CNT);
   assign pop          = (count != '0) & bus.dbg_ready;
   assign push_req     = wr_ok & sel_tx;
   assign push         = push_req & (~full | pop);
   assign ovf_set      = push_req & full & ~pop;
   assign misalign_set = bus.memwrite & ~aligned;
   assign cnt3         = 3'(count);

   assign bus.dbg_valid = (count != '0);
   assign bus.dbg_data  = fifo[rptr];
   assign err           = misalign | tx_ovf;

   always_ff @(posedge clk) begin
      if (ram_we)
         ram[idx] <= bus.writedata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led      <= '0;
         timer    <= '0;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         tx_ovf   <= 1'b0;
         misalign <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            fifo[i] <= '0;
      end else begin
         if (wr_ok & sel_led)
            led <= bus.writedata[15:0];

         timer <= (wr_ok & sel_tmr) ? bus.writedata : timer + 32'd1;

         if (push) begin
            fifo[wptr] <= bus.writedata[7:0];
            wptr       <= wptr + 1'b1;
         end
         if (pop)
            rptr <= rptr + 1'b1;
         if (push & ~pop)
            count <= count + 1'b1;
         else if (pop & ~push)
            count <= count - 1'b1;

         // W1C clears lose to a set event in the same cycle
         if (ovf_set)
            tx_ovf <= 1'b1;
         else if (wr_ok & sel_st & bus.writedata[4])
            tx_ovf <= 1'b0;
         if (misalign_set)
            misalign <= 1'b1;
         else if (wr_ok & sel_st & bus.writedata[5])
            misalign <= 1'b0;
      end
   end

   always_comb begin
      bus.readdata = '0;
      if (mmio) begin
         if (sel_led)
            bus.readdata = {16'b0, led};
         else if (sel_tmr)
            bus.readdata = timer;
         else if (sel_st)
            bus.readdata = {26'b0, misalign, tx_ovf, full, cnt3};
      end else begin
         bus.readdata = ram[idx];
      end
   end
endmodule
